// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side stream adapter.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam logic [1:0] OCC_MAX = 2'd2;

endpackage

// File: rtl/fifo_rd_stream.sv
// Drains a FWFT FIFO read port into a registered valid/ready stream through a
// 2-entry skid buffer, with a delivered-word counter and synchronous flush.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] word_cnt
);

  occ_e             occ_r;
  logic [DSIZE-1:0] main_r;
  logic [DSIZE-1:0] skid_r;
  logic [CNT_W-1:0] word_cnt_r;
  logic             push_s;
  logic             pop_s;

  // The pop request is derived from registered occupancy only, so m_ready never reaches rinc.
  assign push_s   = rrst_n & ~rempty & ~flush & (occ_r != occ_e'(OCC_MAX));
  assign pop_s    = (occ_r != OCC_EMPTY) & m_ready;
  assign rinc     = push_s;
  assign m_valid  = (occ_r != OCC_EMPTY);
  assign m_data   = main_r;
  assign occ      = occ_r;
  assign word_cnt = word_cnt_r;

  // Skid pair occupancy, storage and delivered-word counter.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_r      <= OCC_EMPTY;
      main_r     <= {DSIZE{1'b0}};
      skid_r     <= {DSIZE{1'b0}};
      word_cnt_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      occ_r      <= OCC_EMPTY;
      word_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (pop_s) begin
        word_cnt_r <= word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (occ_r)
        OCC_EMPTY: begin
          if (push_s) begin
            main_r <= rdata;
            occ_r  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push_s && pop_s) begin
            main_r <= rdata;
          end else if (push_s) begin
            skid_r <= rdata;
            occ_r  <= OCC_TWO;
          end else if (pop_s) begin
            occ_r  <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // Full: no push can occur, so only the skid word moves forward.
          if (pop_s) begin
            main_r <= skid_r;
            occ_r  <= OCC_ONE;
          end
        end
        default: begin
          occ_r <= OCC_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised and directed bench for fifo_rd_stream against a queue-based model.
module tb_fifo_rd_stream;

  localparam int DSIZE = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rrst_n;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             flush;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic [1:0]       occ;
  logic [CNT_W-1:0] word_cnt;

  int compared;
  int mismatched;

  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] buf_q[$];
  int               cnt_m;

  fifo_rd_stream #(.DSIZE(DSIZE), .CNT_W(CNT_W)) dut (
    .rclk     (clk),
    .rrst_n   (rrst_n),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .flush    (flush),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .occ      (occ),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".m_valid"}, 32'(m_valid), 32'(buf_q.size() != 0));
    chk({tag, ".occ"}, 32'(occ), 32'(buf_q.size()));
    chk({tag, ".word_cnt"}, 32'(word_cnt), 32'(cnt_m));
    if (buf_q.size() != 0) chk({tag, ".m_data"}, 32'(m_data), 32'(buf_q[0]));
  endtask

  // One clock cycle: drive inputs after negedge, check rinc, advance model, check outputs.
  task automatic step(input string tag, input bit rdy, input bit fl, input bit gap);
    bit exp_rinc;
    bit pop;
    logic [DSIZE-1:0] head;
    m_ready = rdy;
    flush   = fl;
    rempty  = (fifo_q.size() == 0) || gap;
    head    = (fifo_q.size() != 0) ? fifo_q[0] : DSIZE'($urandom);
    rdata   = head;
    #1;
    exp_rinc = rrst_n && !rempty && !fl && (buf_q.size() < 2);
    chk({tag, ".rinc"}, 32'(rinc), 32'(exp_rinc));
    pop = (buf_q.size() != 0) && rdy;
    @(posedge clk);
    if (fl) begin
      buf_q.delete();
      cnt_m = 0;
    end else begin
      if (pop) begin
        void'(buf_q.pop_front());
        cnt_m = (cnt_m + 1) % (1 << CNT_W);
      end
      if (exp_rinc) buf_q.push_back(head);
    end
    if (exp_rinc) void'(fifo_q.pop_front());
    @(negedge clk);
    chk_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rrst_n = 1'b0;
    #1;
    buf_q.delete();
    cnt_m = 0;
    chk({tag, ".rinc"}, 32'(rinc), 32'd0);
    chk({tag, ".m_data"}, 32'(m_data), 32'd0);
    chk_outputs(tag);
    @(negedge clk);
    rrst_n = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cnt_m      = 0;
    rrst_n     = 1'b0;
    flush      = 1'b0;
    m_ready    = 1'b0;
    for (int i = 1; i <= 16; i++) fifo_q.push_back(DSIZE'(i));
    rempty = 1'b0;
    rdata  = fifo_q[0];

    // Reset held with a non-empty FIFO.
    @(negedge clk);
    #1;
    chk("reset.rinc", 32'(rinc), 32'd0);
    chk("reset.m_data", 32'(m_data), 32'd0);
    chk_outputs("reset");
    @(negedge clk);
    rrst_n = 1'b1;

    // Streaming 0x01..0x10 at one word per clock.
    for (int i = 0; i < 19; i++) begin
      step("stream", 1'b1, 1'b0, 1'b0);
      chk("stream.occ_lt2", 32'(occ != 2'd2), 32'd1);
    end
    chk("stream.cnt16", 32'(word_cnt), 32'(16 % (1 << CNT_W)));

    // Backpressure with three queued words.
    for (int i = 1; i <= 3; i++) fifo_q.push_back(DSIZE'(i));
    for (int i = 0; i < 5; i++) step("bp_hold", 1'b0, 1'b0, 1'b0);
    chk("bp.occ2", 32'(occ), 32'd2);
    chk("bp.head", 32'(m_data), 32'h01);
    for (int i = 0; i < 5; i++) step("bp_drain", 1'b1, 1'b0, 1'b0);

    // Alternating empty gaps.
    for (int i = 0; i < 8; i++) fifo_q.push_back(DSIZE'(8'h40 + i));
    for (int i = 0; i < 20; i++) step("gap", 1'b1, 1'b0, i[0]);

    // Flush with a full buffer while the consumer is ready.
    for (int i = 0; i < 6; i++) fifo_q.push_back(DSIZE'(8'h80 + i));
    for (int i = 0; i < 3; i++) step("fl_fill", 1'b0, 1'b0, 1'b0);
    chk("fl.occ2", 32'(occ), 32'd2);
    step("flush", 1'b1, 1'b1, 1'b0);
    chk("flush.cnt0", 32'(word_cnt), 32'd0);
    for (int i = 0; i < 6; i++) step("fl_resume", 1'b1, 1'b0, 1'b0);

    // Wrap: 17 transfers from zero.
    for (int i = 0; i < 17; i++) fifo_q.push_back(DSIZE'($urandom));
    step("wrap_clr", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 19; i++) step("wrap", 1'b1, 1'b0, 1'b0);
    chk("wrap.cnt1", 32'(word_cnt), 32'd1);

    // Randomised traffic with occasional flush and mid-burst async reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) fifo_q.push_back(DSIZE'($urandom));
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 4) == 0));
      if (i == 200) async_reset("async");
    end
    for (int i = 0; i < 4; i++) fifo_q.push_back(DSIZE'($urandom));
    step("pre_rst", 1'b0, 1'b0, 1'b0);
    step("pre_rst", 1'b0, 1'b0, 1'b0);
    async_reset("async_end");
    for (int i = 0; i < 8; i++) step("post_rst", 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
